// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide controller: computes the result at issue,
// holds it in pending registers and commits it after a fixed busy latency.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [63:0] md_res;

  // Returns {HI, LO}; is_signed selects mult vs multu.
  function automatic logic [63:0] mul_result(input logic is_signed,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    return is_signed ? prod_s : prod_u;
  endfunction

  // Returns {remainder, quotient}; zero divisor and the one signed overflow
  // case are resolved explicitly instead of relying on operator behaviour.
  function automatic logic [63:0] div_result(input logic is_signed,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] q_s, r_s;
    logic [63:0]        res;
    q_s = '0;
    r_s = '0;
    if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (is_signed) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        res = {32'd0, 32'h8000_0000};
      end else begin
        q_s = $signed(a) / $signed(b);
        r_s = $signed(a) % $signed(b);
        res = {r_s, q_s};
      end
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    md_res    = '0;
    case (state_q)
      IDLE: begin
        // flush outranks start and the mthi/mtlo writes
        if (flush) begin
          state_d = IDLE;
        end else if (start) begin
          md_res    = op[1] ? div_result(~op[0], A, B) : mul_result(~op[0], A, B);
          pend_hi_d = md_res[63:32];
          pend_lo_d = md_res[31:0];
          cnt_d     = op[1] ? DIV_LOAD : MUL_LOAD;
          state_d   = op[1] ? DIV : MUL;
          busy_d    = 1'b1;
        end else begin
          if (we_hi) hi_d = A;
          if (we_lo) lo_d = A;
        end
      end
      default: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == 5'd0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random operations
// compared against a plain-arithmetic HI/LO reference model.
module tb_muldiv_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n, start, we_hi, we_lo, flush;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .we_hi(we_hi), .we_lo(we_lo), .flush(flush),
    .busy(busy), .HI(HI), .LO(LO)
  );

  // Reference: {HI, LO} from 64-bit integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint     sa, sb, q, r;
    bit [63:0]  ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: begin q = sa * sb; return q; end
      2'b01: begin p = ua * ub; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hilo(input string name);
    checks++;
    if (HI !== hi_m || LO !== lo_m) begin
      errors++;
      $display("FAIL %s: HI=%h LO=%h, expected HI=%h LO=%h", name, HI, LO, hi_m, lo_m);
    end
  endtask

  task automatic check_busy(input string name, input logic exp);
    checks++;
    if (busy !== exp) begin
      errors++;
      $display("FAIL %s: busy=%b, expected %b", name, busy, exp);
    end
  endtask

  // Issue one operation, count busy cycles, then check latency and result.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit disturb, input bit with_we, input string name);
    logic [63:0] exp;
    int          n, lat;
    bit          held;
    logic [31:0] hi_old, lo_old;
    hi_old = hi_m;
    lo_old = lo_m;
    lat    = o[1] ? DC : MC;
    exp    = ref_op(o, a, b);
    op = o; A = a; B = b; we_hi = with_we; we_lo = with_we; start = 1'b1;
    step();
    start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom);
    n = 0;
    held = 1'b1;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (HI !== hi_old || LO !== lo_old) held = 1'b0;
      if (disturb) begin
        start = 1'($urandom); op = 2'($urandom); A = $urandom; B = $urandom;
        we_hi = 1'($urandom); we_lo = 1'($urandom);
      end
      step();
    end
    start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s latency: busy cycles=%0d, expected %0d", name, n, lat);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s hold: HI/LO changed while busy, expected %h/%h", name, hi_old, lo_old);
    end
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    check_hilo(name);
  endtask

  task automatic write_mt(input bit h, input bit l, input logic [31:0] a, input string name);
    we_hi = h; we_lo = l; A = a;
    step();
    we_hi = 1'b0; we_lo = 1'b0;
    if (h) hi_m = a;
    if (l) lo_m = a;
    check_hilo(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 0; we_hi = 0; we_lo = 0; flush = 0; op = 0; A = 0; B = 0;
    #2 rst_n = 1'b0;
    #1;
    check_busy("reset_busy", 1'b0);
    check_hilo("reset_hilo");
    step();
    step();
    #3 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_directed();
    step();
    issue(2'b00, 32'hFFFF_FFFE, 32'd3, 0, 0, "mult_neg2x3");
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, "multu_max_x2");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg7_2");
    issue(2'b11, 32'd7, 32'd0, 0, 0, "divu_by_zero");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_overflow");
    issue(2'b10, 32'h8000_0001, 32'd0, 0, 0, "div_by_zero");
  endtask

  task automatic test_mthi_mtlo();
    write_mt(1, 0, 32'h1234_5678, "mthi_idle");
    write_mt(0, 1, 32'h0BAD_F00D, "mtlo_idle");
    write_mt(1, 1, 32'hCAFE_0001, "mthi_mtlo_both");
    issue(2'b01, 32'd1000, 32'd3000, 1, 0, "mult_busy_disturbed");
    issue(2'b00, 32'd6, 32'hFFFF_FFF9, 0, 1, "start_with_we");
  endtask

  task automatic test_flush(input int k, input string name);
    write_mt(1, 0, 32'h1111_1111, "flush_setup_hi");
    write_mt(0, 1, 32'h2222_2222, "flush_setup_lo");
    op = 2'b10; A = 32'd100; B = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < k; c++) step();
    check_busy({name, "_before"}, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_busy({name, "_busy"}, 1'b0);
    check_hilo({name, "_hilo"});
    step();
    step();
    check_hilo({name, "_later"});
  endtask

  task automatic test_idle_flush();
    flush = 1'b1; start = 1'b1; we_hi = 1'b1; we_lo = 1'b1; op = 2'b00; A = 32'h5555_AAAA; B = 32'd9;
    step();
    flush = 1'b0; start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    check_busy("idle_flush_busy", 1'b0);
    check_hilo("idle_flush_hilo");
  endtask

  task automatic test_reset_mid();
    write_mt(1, 1, 32'h7777_7777, "rst_mid_setup");
    op = 2'b00; A = 32'd12; B = 32'd13; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    hi_m = '0;
    lo_m = '0;
    check_busy("rst_mid_busy", 1'b0);
    check_hilo("rst_mid_hilo");
    #3 rst_n = 1'b1;
    issue(2'b00, 32'd12, 32'd13, 0, 0, "after_reset_start");
  endtask

  task automatic test_back_to_back();
    issue(2'b01, 32'h0001_0000, 32'h0001_0000, 0, 0, "b2b_1");
    issue(2'b11, 32'hFFFF_FFFF, 32'd10, 0, 0, "b2b_2");
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, "b2b_3");
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      issue(2'($urandom), ra, rb, 1'($urandom), 1'($urandom), "random_op");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_flush(4, "flush_4th");
    test_flush(DC, "flush_commit");
    test_idle_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
